// File: rtl/scanchain_pkg.sv
// ----------------------------------------------------------------------------
// scanchain_pkg
// Shared definitions for the merge-core scan wrapper: sequencer states,
// tester command encodings and the chain field map derived from the widths.
// Chain layout, LSB first:
//   [2:0]   control bits {wr_en, mode, core_en}
//   next    run-cycle budget  (run_w bits)
//   next    core input payload (in_w bits)
//   next    core result capture (out_w bits)
//   MSB     timeout flag
// ----------------------------------------------------------------------------
package scanchain_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_UPDATE  = 3'd2,
      ST_RUN     = 3'd3,
      ST_CAPTURE = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CMD_NOP     = 2'b00,
      CMD_SHIFT   = 2'b01,
      CMD_RUN     = 2'b10,
      CMD_CAPTURE = 2'b11
   } cmd_e;

   localparam int CTL_W           = 3;
   localparam int CTL_LSB         = 0;
   localparam int CTL_CORE_EN_BIT = 0;
   localparam int CTL_MODE_BIT    = 1;
   localparam int CTL_WR_EN_BIT   = 2;
   localparam int RUN_CNT_LSB     = CTL_W;

   function automatic int payload_lsb(input int run_w);
      return RUN_CNT_LSB + run_w;
   endfunction

   function automatic int capture_lsb(input int run_w, input int in_w);
      return payload_lsb(run_w) + in_w;
   endfunction

   // Shadow holds everything below the capture field.
   function automatic int shadow_w(input int run_w, input int in_w);
      return capture_lsb(run_w, in_w);
   endfunction

   function automatic int sc_len(input int in_w, input int out_w, input int run_w);
      return CTL_W + run_w + in_w + out_w + 1;
   endfunction

   function automatic int timeout_pos(input int in_w, input int out_w, input int run_w);
      return sc_len(in_w, out_w, run_w) - 1;
   endfunction

endpackage

// File: rtl/scanchain_run_timer.sv
// ----------------------------------------------------------------------------
// scanchain_run_timer
// Run-cycle budget counter for the scan sequencer. Loads the budget when the
// shadow is updated, counts down while the core runs, and resolves whether
// the run ended on core completion or on budget exhaustion.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   load_i          load budget (UPDATE cycle), clears the timeout flag
//   run_i           core is running this cycle
//   clr_i           capture cycle: timeout flag consumed, cleared afterwards
//   cycles_i        scanned-in run budget
//   core_done_i     core completion
//   zero_budget_o   budget is zero: skip RUN entirely
//   finish_o        this RUN cycle is the last one
//   timeout_o       last run ended without core completion
// ----------------------------------------------------------------------------
module scanchain_run_timer #(
   parameter int RUN_CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic                 run_i,
   input  logic                 clr_i,
   input  logic [RUN_CNT_W-1:0] cycles_i,
   input  logic                 core_done_i,
   output logic                 zero_budget_o,
   output logic                 finish_o,
   output logic                 timeout_o
);

   logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic                 timeout_q, timeout_d;

   assign zero_budget_o = (cycles_i == '0);
   // Completion wins over the last budgeted cycle, so both end the run here.
   assign finish_o      = run_i && (core_done_i || (run_cnt_q == RUN_CNT_W'(1)));
   assign timeout_o     = timeout_q;

   always_comb begin
      run_cnt_d = run_cnt_q;
      timeout_d = timeout_q;
      if (load_i) begin
         run_cnt_d = cycles_i;
         timeout_d = 1'b0;
      end else if (run_i) begin
         run_cnt_d = run_cnt_q - RUN_CNT_W'(1);
         if (finish_o) timeout_d = ~core_done_i;
      end else if (clr_i) begin
         // A later explicit CAPTURE must not report a stale timeout.
         timeout_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: rtl/scanchain_merge_ctrl.sv
// ----------------------------------------------------------------------------
// scanchain_merge_ctrl
// Single-clock scan chain with a built-in sequencer between the tester scan
// pins and the spmv merge core. SHIFT moves exactly SC_LEN bits, RUN loads
// the shadow register and runs the core for the scanned budget, CAPTURE
// stores {timeout, core result} into the top of the chain.
// Ports:
//   scan_clk, rst          clock, synchronous active-high reset
//   cmd_valid, cmd         command strobe/code, taken only when cmd_ready
//   cmd_ready              sequencer idle and not in reset
//   scan_in                serial data in (SHIFT)
//   scan_out               chain MSB, always driven
//   scan_out_valid         high during SHIFT
//   run_done               one-cycle pulse in CAPTURE
//   core_en                shadow core_en gated by RUN
//   wr_en_core_input       shadow wr_en gated by RUN
//   mode                   shadow mode bit
//   core_in_bus            shadow payload to the core
//   core_out_bus           core result, captured in CAPTURE
//   core_done              core completion, sampled in RUN
// ----------------------------------------------------------------------------
module scanchain_merge_ctrl
   import scanchain_pkg::*;
#(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 48,
   parameter int RUN_CNT_W = 16
) (
   input  logic             scan_clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd,
   output logic             cmd_ready,
   input  logic             scan_in,
   output logic             scan_out,
   output logic             scan_out_valid,
   output logic             run_done,
   output logic             core_en,
   output logic             wr_en_core_input,
   output logic             mode,
   output logic [IN_W-1:0]  core_in_bus,
   input  logic [OUT_W-1:0] core_out_bus,
   input  logic             core_done
);

   localparam int SC_LEN   = sc_len(IN_W, OUT_W, RUN_CNT_W);
   localparam int SHADOW_W = shadow_w(RUN_CNT_W, IN_W);
   localparam int PAY_LSB  = payload_lsb(RUN_CNT_W);
   localparam int CNT_W    = $clog2(SC_LEN);

   state_e              state_q, state_d;
   logic [SC_LEN-1:0]   chain_q, chain_d;
   logic [SHADOW_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0]    shift_cnt_q, shift_cnt_d;

   logic timer_zero, timer_finish, timer_timeout;

   scanchain_run_timer #(
      .RUN_CNT_W (RUN_CNT_W)
   ) u_run_timer (
      .clk_i         (scan_clk),
      .rst_i         (rst),
      .load_i        (state_q == ST_UPDATE),
      .run_i         (state_q == ST_RUN),
      .clr_i         (state_q == ST_CAPTURE),
      .cycles_i      (chain_q[RUN_CNT_LSB +: RUN_CNT_W]),
      .core_done_i   (core_done),
      .zero_budget_o (timer_zero),
      .finish_o      (timer_finish),
      .timeout_o     (timer_timeout)
   );

   always_ff @(posedge scan_clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         chain_q     <= '0;
         shadow_q    <= '0;
         shift_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         chain_q     <= chain_d;
         shadow_q    <= shadow_d;
         shift_cnt_q <= shift_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_e'(cmd))
                  CMD_SHIFT:   state_d = ST_SHIFT;
                  CMD_RUN:     state_d = ST_UPDATE;
                  CMD_CAPTURE: state_d = ST_CAPTURE;
                  default:     state_d = ST_IDLE;
               endcase
            end
         end
         ST_SHIFT:   if (shift_cnt_q == '0) state_d = ST_IDLE;
         ST_UPDATE:  state_d = timer_zero ? ST_CAPTURE : ST_RUN;
         ST_RUN:     if (timer_finish) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Chain, shadow and shift counter. The counter is preloaded with SC_LEN-1
   // on entry so SHIFT lasts exactly SC_LEN cycles.
   always_comb begin
      chain_d     = chain_q;
      shadow_d    = shadow_q;
      shift_cnt_d = shift_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && (cmd_e'(cmd) == CMD_SHIFT))
               shift_cnt_d = CNT_W'(SC_LEN - 1);
         end
         ST_SHIFT: begin
            chain_d = {chain_q[SC_LEN-2:0], scan_in};
            if (shift_cnt_q != '0) shift_cnt_d = shift_cnt_q - CNT_W'(1);
         end
         ST_UPDATE:  shadow_d = chain_q[SHADOW_W-1:0];
         ST_CAPTURE: chain_d[SC_LEN-1 -: OUT_W+1] = {timer_timeout, core_out_bus};
         default: ;
      endcase
   end

   always_comb begin
      cmd_ready        = (state_q == ST_IDLE) && !rst;
      scan_out_valid   = (state_q == ST_SHIFT);
      run_done         = (state_q == ST_CAPTURE);
      core_en          = shadow_q[CTL_CORE_EN_BIT] && (state_q == ST_RUN);
      wr_en_core_input = shadow_q[CTL_WR_EN_BIT] && (state_q == ST_RUN);
   end

   assign scan_out    = chain_q[SC_LEN-1];
   assign mode        = shadow_q[CTL_MODE_BIT];
   assign core_in_bus = shadow_q[PAY_LSB +: IN_W];

endmodule
